// File: rtl/spi_regif_pkg.sv
// Shared types and helpers for the spi_regif SPI register interface.
//   cmd_e       : two-bit command class taken from cmd[7:6]
//   state_e     : frame state machine encoding
//   edge_select : maps {CPOL,CPHA} and sclk rise/fall pulses to
//                 {sample pulse, change pulse}
package spi_regif_pkg;

    typedef enum logic [1:0] {
        RD   = 2'b00,
        RSVD = 2'b01,
        WR   = 2'b10,
        FAST = 2'b11
    } cmd_e;

    typedef enum logic [2:0] {
        WAIT_DESEL = 3'd0,
        IDLE       = 3'd1,
        CMD        = 3'd2,
        DATA       = 3'd3,
        DISCARD    = 3'd4
    } state_e;

    // Sample on the rising edge when CPOL==CPHA, otherwise on the falling
    // edge; the change edge is always the other one.
    function automatic logic [1:0] edge_select(input logic [1:0] spi_mode,
                                               input logic       rise,
                                               input logic       fall);
        logic [1:0] sel;
        if (spi_mode[1] == spi_mode[0]) begin
            sel = {rise, fall};
        end else begin
            sel = {fall, rise};
        end
        return sel;
    endfunction

endpackage

// File: rtl/spi_regif_sync_edge.sv
// N-flop synchroniser with registered edge pulses.
//   clk, rst : system clock, synchronous active-high reset
//   din      : asynchronous pin
//   level    : synchronised level, aligned with the rise/fall pulses
//   rise     : 1-cycle pulse after a 0->1 transition of din
//   fall     : 1-cycle pulse after a 1->0 transition of din
// A pin transition shows up on rise/fall three clk cycles later (N=2).
module spi_sync_edge #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [N-1:0] sync;
    logic         prev;

    // Synchroniser chain plus one delay stage used for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= '0;
            prev <= 1'b0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            sync <= {sync[N-2:0], din};
            prev <= sync[N-1];
            rise <= sync[N-1] & ~prev;
            fall <= ~sync[N-1] & prev;
        end
    end

    assign level = prev;

endmodule

// File: rtl/spi_regif.sv
// SPI-slave register interface with CPOL/CPHA selection, one command byte
// and burst register transfers with address auto-increment.
//   clk, rst        : system clock (>=4x sclk), synchronous active-high reset
//   mode            : {CPOL,CPHA}, captured at frame start
//   sclk/mosi/nss   : asynchronous SPI pins, miso : serial output
//   reg_addr        : current register address
//   reg_data_i      : combinational read data for reg_addr
//   reg_rd_stb      : pulse when reg_data_i is captured
//   reg_data_o/_vld : write data and 1-cycle write strobe
//   status          : returned left-justified during the command byte
//   fastcmd/_vld    : fast-command code and 1-cycle pulse
//   frame_err       : pulse when a frame ends mid-byte/mid-word
//   busy            : high while a frame is active
module spi_regif
    import spi_regif_pkg::*;
#(
    parameter int ADDR_W   = 3,
    parameter int REG_W    = 8,
    parameter int STATUS_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          mode,
    input  logic                sclk,
    input  logic                mosi,
    input  logic                nss,
    output logic                miso,
    output logic [ADDR_W-1:0]   reg_addr,
    input  logic [REG_W-1:0]    reg_data_i,
    output logic                reg_rd_stb,
    output logic [REG_W-1:0]    reg_data_o,
    output logic                reg_data_o_vld,
    input  logic [STATUS_W-1:0] status,
    output logic [5:0]          fastcmd,
    output logic                fastcmd_vld,
    output logic                frame_err,
    output logic                busy
);

    localparam logic [5:0] LAST_BIT = 6'(REG_W - 1);

    logic             sclk_level, sclk_rise, sclk_fall;
    logic             nss_level, nss_rise, nss_fall;
    logic [1:0]       mosi_sync;
    logic [1:0]       edge_s;
    logic             samp_s, chg_s;
    logic [REG_W-1:0] rx_next_s;

    state_e           state;
    cmd_e             cmd_r;
    logic [1:0]       mode_r;
    logic [REG_W-1:0] rx_sr;
    logic [REG_W-1:0] tx_sr;
    logic [5:0]       bit_cnt;
    logic             skip_shift;
    logic             inc_pend;
    logic             ld_pend;

    spi_sync_edge #(.N(2)) u_sclk_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (sclk),
        .level (sclk_level),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    spi_sync_edge #(.N(2)) u_nss_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (nss),
        .level (nss_level),
        .rise  (nss_rise),
        .fall  (nss_fall)
    );

    // Two-flop synchroniser for mosi; it is stable around the sample edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            mosi_sync <= 2'b00;
        end else begin
            mosi_sync <= {mosi_sync[0], mosi};
        end
    end

    // Sample/change pulse selection and the next receive-shift value.
    always_comb begin
        edge_s    = edge_select(mode_r, sclk_rise, sclk_fall);
        samp_s    = edge_s[1];
        chg_s     = edge_s[0];
        rx_next_s = {rx_sr[REG_W-2:0], mosi_sync[1]};
    end

    // Frame state machine, transmit/receive shifting and register strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= WAIT_DESEL;
            cmd_r          <= RD;
            mode_r         <= 2'b00;
            rx_sr          <= '0;
            tx_sr          <= '0;
            bit_cnt        <= 6'd0;
            skip_shift     <= 1'b0;
            inc_pend       <= 1'b0;
            ld_pend        <= 1'b0;
            reg_addr       <= '0;
            reg_rd_stb     <= 1'b0;
            reg_data_o     <= '0;
            reg_data_o_vld <= 1'b0;
            fastcmd        <= 6'd0;
            fastcmd_vld    <= 1'b0;
            frame_err      <= 1'b0;
            busy           <= 1'b0;
        end else begin
            reg_rd_stb     <= 1'b0;
            reg_data_o_vld <= 1'b0;
            fastcmd_vld    <= 1'b0;
            frame_err      <= 1'b0;

            // Change edge: the first change edge after a word load (or the
            // first of a CPHA=1 frame) only presents the already-loaded MSB.
            if (busy && chg_s) begin
                if (skip_shift) begin
                    skip_shift <= 1'b0;
                end else begin
                    tx_sr <= {tx_sr[REG_W-2:0], 1'b0};
                end
            end

            // Read-data capture; wins over a coincident change edge, which
            // is always a skipped one at a word boundary.
            if (ld_pend) begin
                tx_sr      <= reg_data_i;
                reg_rd_stb <= 1'b1;
                ld_pend    <= 1'b0;
            end

            // Address increment one cycle after a word boundary; reads then
            // fetch the following word.
            if (inc_pend) begin
                reg_addr <= reg_addr + ADDR_W'(1);
                inc_pend <= 1'b0;
                if (state == DATA && cmd_r == RD) begin
                    ld_pend <= 1'b1;
                end else begin
                    ld_pend <= 1'b0;
                end
            end

            if (nss_rise) begin
                // Deselect ends the frame from any state; a sample edge in
                // the same cycle is dropped.
                if ((state == CMD || state == DATA || state == DISCARD) &&
                    bit_cnt != 6'd0) begin
                    frame_err <= 1'b1;
                end else begin
                    frame_err <= 1'b0;
                end
                state   <= IDLE;
                busy    <= 1'b0;
                bit_cnt <= 6'd0;
                ld_pend <= 1'b0;
                tx_sr   <= '0;
            end else begin
                case (state)
                    WAIT_DESEL: begin
                        if (nss_level) begin
                            state <= IDLE;
                        end else begin
                            state <= WAIT_DESEL;
                        end
                    end
                    IDLE: begin
                        if (nss_fall) begin
                            state      <= CMD;
                            mode_r     <= mode;
                            tx_sr      <= REG_W'(status) << (REG_W - STATUS_W);
                            bit_cnt    <= 6'd0;
                            busy       <= 1'b1;
                            skip_shift <= mode[0];
                        end else begin
                            state <= IDLE;
                        end
                    end
                    CMD: begin
                        if (samp_s) begin
                            rx_sr <= rx_next_s;
                            if (bit_cnt == 6'd7) begin
                                bit_cnt    <= 6'd0;
                                skip_shift <= 1'b1;
                                cmd_r      <= cmd_e'(rx_next_s[7:6]);
                                case (cmd_e'(rx_next_s[7:6]))
                                    FAST: begin
                                        fastcmd     <= rx_next_s[5:0];
                                        fastcmd_vld <= 1'b1;
                                        tx_sr       <= '0;
                                        state       <= WAIT_DESEL;
                                    end
                                    WR: begin
                                        reg_addr <= rx_next_s[ADDR_W-1:0];
                                        tx_sr    <= '0;
                                        state    <= DATA;
                                    end
                                    RD: begin
                                        reg_addr <= rx_next_s[ADDR_W-1:0];
                                        ld_pend  <= 1'b1;
                                        state    <= DATA;
                                    end
                                    default: begin
                                        tx_sr <= '0;
                                        state <= DISCARD;
                                    end
                                endcase
                            end else begin
                                bit_cnt <= bit_cnt + 6'd1;
                            end
                        end else begin
                            state <= CMD;
                        end
                    end
                    DATA: begin
                        if (samp_s) begin
                            rx_sr <= rx_next_s;
                            if (bit_cnt == LAST_BIT) begin
                                bit_cnt    <= 6'd0;
                                skip_shift <= 1'b1;
                                inc_pend   <= 1'b1;
                                if (cmd_r == WR) begin
                                    reg_data_o     <= rx_next_s;
                                    reg_data_o_vld <= 1'b1;
                                end else begin
                                    reg_data_o_vld <= 1'b0;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 6'd1;
                            end
                        end else begin
                            state <= DATA;
                        end
                    end
                    DISCARD: begin
                        if (samp_s) begin
                            if (bit_cnt == 6'd7) begin
                                bit_cnt <= 6'd0;
                            end else begin
                                bit_cnt <= bit_cnt + 6'd1;
                            end
                        end else begin
                            state <= DISCARD;
                        end
                    end
                    default: begin
                        state <= WAIT_DESEL;
                    end
                endcase
            end
        end
    end

    assign miso = tx_sr[REG_W-1];

endmodule

// File: tb/tb_spi_regif.sv
module tb_spi_regif;

    localparam int ADDR_W   = 3;
    localparam int REG_W    = 16;
    localparam int STATUS_W = 8;
    localparam int HALF     = 6;

    logic                clk = 1'b0;
    logic                rst;
    logic [1:0]          mode;
    logic                sclk, mosi, nss;
    logic                miso;
    logic [ADDR_W-1:0]   reg_addr;
    logic [REG_W-1:0]    reg_data_i;
    logic                reg_rd_stb;
    logic [REG_W-1:0]    reg_data_o;
    logic                reg_data_o_vld;
    logic [STATUS_W-1:0] status;
    logic [5:0]          fastcmd;
    logic                fastcmd_vld, frame_err, busy;

    logic [REG_W-1:0] regs [0:7];
    int n_vec = 0, n_err = 0;
    int rd_cnt = 0, fast_cnt = 0, err_cnt = 0;
    int rd0, f0, e0;
    logic [31:0] miso_q [$];
    logic [31:0] wr_q [$];
    logic [31:0] dummy;

    spi_regif #(.ADDR_W(ADDR_W), .REG_W(REG_W), .STATUS_W(STATUS_W)) dut (
        .clk(clk), .rst(rst), .mode(mode), .sclk(sclk), .mosi(mosi), .nss(nss),
        .miso(miso), .reg_addr(reg_addr), .reg_data_i(reg_data_i),
        .reg_rd_stb(reg_rd_stb), .reg_data_o(reg_data_o),
        .reg_data_o_vld(reg_data_o_vld), .status(status), .fastcmd(fastcmd),
        .fastcmd_vld(fastcmd_vld), .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;
    assign reg_data_i = regs[reg_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Output monitor: counts pulses and scores write strobes.
    always @(negedge clk) begin
        if (reg_rd_stb) rd_cnt++;
        if (fastcmd_vld) fast_cnt++;
        if (frame_err) err_cnt++;
        if (reg_data_o_vld) begin
            if (wr_q.size() == 0) begin
                check("wr_unexpected", {13'd0, reg_addr, reg_data_o}, 32'hFFFF_FFFF);
            end else begin
                check("wr_data", {13'd0, reg_addr, reg_data_o}, wr_q.pop_front());
            end
        end
    end

    task automatic half();
        repeat (HALF) @(negedge clk);
    endtask

    task automatic begin_frame(input logic [1:0] m, input logic [7:0] st);
        mode   = m;
        status = st;
        sclk   = m[1];
        repeat (4) @(negedge clk);
        nss = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic end_frame();
        half();
        nss = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    // Master side: shifts tx out MSB first and captures miso at each sample edge.
    task automatic xfer(input int nbits, input logic [31:0] tx, output logic [31:0] rx);
        rx = 32'd0;
        for (int i = nbits - 1; i >= 0; i--) begin
            if (!mode[0]) begin
                mosi = tx[i];
                half();
                rx = {rx[30:0], miso};
                sclk = ~mode[1];
                half();
                sclk = mode[1];
            end else begin
                sclk = ~mode[1];
                mosi = tx[i];
                half();
                rx = {rx[30:0], miso};
                sclk = mode[1];
                half();
            end
        end
    endtask

    task automatic xfer_chk(input int nbits, input logic [31:0] tx);
        logic [31:0] rx;
        xfer(nbits, tx, rx);
        if (miso_q.size() == 0) begin
            check("miso_unexpected", rx, 32'hFFFF_FFFF);
        end else begin
            check("miso", rx, miso_q.pop_front());
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 8; i++) regs[i] = 16'(i * 16'h0101);
        rst = 1'b1; nss = 1'b1; sclk = 1'b0; mosi = 1'b0; mode = 2'b00; status = 8'h5A;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        check("rst_miso", {31'd0, miso}, 32'd0);
        check("rst_addr", {29'd0, reg_addr}, 32'd0);
        check("rst_wdata", {16'd0, reg_data_o}, 32'd0);
        check("rst_fastcmd", {26'd0, fastcmd}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);

        // Mode 01 burst write at 3
        begin_frame(2'b01, 8'h5A);
        miso_q.push_back(32'h5A);
        xfer_chk(8, 32'h83);
        check("wr_busy", {31'd0, busy}, 32'd1);
        wr_q.push_back({13'd0, 3'd3, 16'hA5C3});
        miso_q.push_back(32'h0);
        xfer_chk(16, 32'hA5C3);
        wr_q.push_back({13'd0, 3'd4, 16'h3C5A});
        miso_q.push_back(32'h0);
        xfer_chk(16, 32'h3C5A);
        end_frame();
        check("wr_addr_after", {29'd0, reg_addr}, 32'd5);
        check("wr_busy_after", {31'd0, busy}, 32'd0);
        check("wr_frame_err", err_cnt, 0);
        check("wr_all_seen", wr_q.size(), 0);

        // Mode 00 burst read from 7 with wrap to 0
        regs[7] = 16'h1234; regs[0] = 16'hBEEF; regs[1] = 16'h5555;
        rd0 = rd_cnt;
        begin_frame(2'b00, 8'h5A);
        miso_q.push_back(32'h5A);
        miso_q.push_back(32'h1234);
        miso_q.push_back(32'hBEEF);
        xfer_chk(8, 32'h07);
        xfer_chk(16, 32'h0);
        xfer_chk(16, 32'h0);
        end_frame();
        check("rd_strobes", rd_cnt - rd0, 3);
        check("rd_addr_after", {29'd0, reg_addr}, 32'd1);

        // Fast commands in modes 10 and 11; trailing byte ignored
        f0 = fast_cnt;
        begin_frame(2'b10, 8'hC3);
        miso_q.push_back(32'hC3);
        miso_q.push_back(32'h0);
        xfer_chk(8, 32'hE5);
        xfer_chk(8, 32'hFF);
        end_frame();
        check("fast10_code", {26'd0, fastcmd}, 32'h25);
        check("fast10_pulses", fast_cnt - f0, 1);
        f0 = fast_cnt;
        begin_frame(2'b11, 8'h96);
        miso_q.push_back(32'h96);
        miso_q.push_back(32'h0);
        xfer_chk(8, 32'hFA);
        xfer_chk(8, 32'h81);
        end_frame();
        check("fast11_code", {26'd0, fastcmd}, 32'h3A);
        check("fast11_pulses", fast_cnt - f0, 1);
        check("fast_addr", {29'd0, reg_addr}, 32'd1);

        // Truncated write word
        e0 = err_cnt;
        begin_frame(2'b01, 8'h5A);
        miso_q.push_back(32'h5A);
        xfer_chk(8, 32'h82);
        xfer(5, 32'h16, dummy);
        end_frame();
        check("trunc_frame_err", err_cnt - e0, 1);
        check("trunc_busy", {31'd0, busy}, 32'd0);
        check("trunc_addr", {29'd0, reg_addr}, 32'd2);

        // Reserved command discards the rest of the frame
        e0 = err_cnt; f0 = fast_cnt; rd0 = rd_cnt;
        begin_frame(2'b00, 8'h5A);
        miso_q.push_back(32'h5A);
        miso_q.push_back(32'h0);
        xfer_chk(8, 32'h45);
        xfer_chk(8, 32'hA5);
        end_frame();
        check("rsvd_frame_err", err_cnt - e0, 0);
        check("rsvd_fast", fast_cnt - f0, 0);
        check("rsvd_rd", rd_cnt - rd0, 0);
        check("rsvd_addr", {29'd0, reg_addr}, 32'd2);

        // Reset in the middle of a read with nss held low
        begin_frame(2'b00, 8'h5A);
        miso_q.push_back(32'h5A);
        xfer_chk(8, 32'h00);
        xfer(4, 32'h0, dummy);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("midrst_miso", {31'd0, miso}, 32'd0);
        check("midrst_addr", {29'd0, reg_addr}, 32'd0);
        check("midrst_wdata", {16'd0, reg_data_o}, 32'd0);
        check("midrst_fastcmd", {26'd0, fastcmd}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        rd0 = rd_cnt; e0 = err_cnt;
        xfer(16, 32'hFFFF, dummy);
        check("postrst_busy", {31'd0, busy}, 32'd0);
        check("postrst_rd", rd_cnt - rd0, 0);
        check("postrst_miso", dummy, 32'd0);
        end_frame();
        check("postrst_err", err_cnt - e0, 0);

        // Normal frame accepted after deselect
        begin_frame(2'b00, 8'h5A);
        miso_q.push_back(32'h5A);
        xfer_chk(8, 32'h81);
        wr_q.push_back({13'd0, 3'd1, 16'h0F0F});
        miso_q.push_back(32'h0);
        xfer_chk(16, 32'h0F0F);
        end_frame();
        check("recover_addr", {29'd0, reg_addr}, 32'd2);
        check("recover_wr_seen", wr_q.size(), 0);
        check("miso_q_empty", miso_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
